// File: rtl/ex_stage.sv
// EX stage: forwarding, RV32I ALU, branch resolve, EX/MEM register; 1-cycle latency, never stalls by default.
// `EX_MULDIV_EN adds an iterative RV32M unit that raises stall_out for 33 cycles per op (bubbles into EX/MEM meanwhile).
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_in,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic [XLEN-1:0] immData_in,
  input  logic [4:0]      rd_in,
  input  logic [3:0]      Funct_in,
  input  logic [1:0]      ALUOp_in,
  input  logic            Branch_in,
  input  logic            MemRead_in,
  input  logic            MemtoReg_in,
  input  logic            MemWrite_in,
  input  logic            ALUSrc_in,
  input  logic            RegWrite_in,
  input  logic            MulDiv_in,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush_in,
  output logic            stall_out,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] BranchTarget,
  output logic            BranchTaken,
  output logic [4:0]      rd,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            RegWrite
);

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, md_result;
  logic [3:0]      funct_eff;
  logic [4:0]      shamt;
  logic            br_cond;

  always_comb begin
    fwd_a = data1_in;
    fwd_b = data2_in;
    case (ForwardA)
      2'b10:   fwd_a = fwd_mem_data;
      2'b01:   fwd_a = fwd_wb_data;
      default: fwd_a = data1_in;
    endcase
    case (ForwardB)
      2'b10:   fwd_b = fwd_mem_data;
      2'b01:   fwd_b = fwd_wb_data;
      default: fwd_b = data2_in;
    endcase
    op_b  = ALUSrc_in ? immData_in : fwd_b;
    shamt = op_b[4:0];
  end

  // I-type carries instr[30] only for srai; elsewhere it is immediate bits
  always_comb begin
    funct_eff = Funct_in;
    if (ALUOp_in == 2'b11 && Funct_in[2:0] != 3'b101) funct_eff[3] = 1'b0;
    alu_res = '0;
    case (ALUOp_in)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      default: begin
        case (funct_eff)
          4'b0000: alu_res = fwd_a + op_b;
          4'b1000: alu_res = fwd_a - op_b;
          4'b0001: alu_res = fwd_a << shamt;
          4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
          4'b0011: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
          4'b0100: alu_res = fwd_a ^ op_b;
          4'b0101: alu_res = fwd_a >> shamt;
          4'b1101: alu_res = $unsigned($signed(fwd_a) >>> shamt);
          4'b0110: alu_res = fwd_a | op_b;
          4'b0111: alu_res = fwd_a & op_b;
          default: alu_res = '0;
        endcase
      end
    endcase
    case (Funct_in[2:0])
      3'b000:  br_cond = (fwd_a == op_b);
      3'b001:  br_cond = (fwd_a != op_b);
      3'b100:  br_cond = ($signed(fwd_a) < $signed(op_b));
      3'b101:  br_cond = ($signed(fwd_a) >= $signed(op_b));
      3'b110:  br_cond = (fwd_a < op_b);
      3'b111:  br_cond = (fwd_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;
  md_state_t         state, state_nxt;
  logic [4:0]        cnt;
  logic [2:0]        md_op;
  logic [XLEN-1:0]   md_opnd, md_hi, md_lo, abs_a, abs_b;
  logic              md_neg, md_negr, md_div0, sgn_a, sgn_b, md_start;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] md_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MulDiv_in && !flush_in) state_nxt = BUSY;
      BUSY:    if (flush_in) state_nxt = IDLE;
               else if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    stall_out = reset && MulDiv_in && (state != DONE) && !flush_in;
  end

  // Unsigned magnitudes are iterated; signs are reapplied on the way out
  always_comb begin
    md_start  = (state == IDLE) && (state_nxt == BUSY);
    sgn_a     = fwd_a[XLEN-1] & ((Funct_in[2:0] == 3'b001) | (Funct_in[2:0] == 3'b010) |
                                 (Funct_in[2] & ~Funct_in[0]));
    sgn_b     = fwd_b[XLEN-1] & ((Funct_in[2:0] == 3'b001) | (Funct_in[2] & ~Funct_in[0]));
    abs_a     = sgn_a ? -fwd_a : fwd_a;
    abs_b     = sgn_b ? -fwd_b : fwd_b;
    mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opnd} : {(XLEN+1){1'b0}});
    div_shift = {md_hi, md_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, md_opnd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      md_op   <= '0;
      md_opnd <= '0;
      md_hi   <= '0;
      md_lo   <= '0;
      md_neg  <= 1'b0;
      md_negr <= 1'b0;
      md_div0 <= 1'b0;
    end else if (md_start) begin
      cnt     <= '0;
      md_op   <= Funct_in[2:0];
      md_hi   <= '0;
      md_opnd <= Funct_in[2] ? abs_b : abs_a;
      md_lo   <= Funct_in[2] ? abs_a : abs_b;
      md_neg  <= sgn_a ^ sgn_b;
      md_negr <= sgn_a;
      md_div0 <= (fwd_b == '0);
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      if (!md_op[2]) begin
        {md_hi, md_lo} <= {mul_sum, md_lo[XLEN-1:1]};
      end else begin
        md_hi <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        md_lo <= {md_lo[XLEN-2:0], ~div_trial[XLEN]};
      end
    end
  end

  always_comb begin
    md_prod = {md_hi, md_lo};
    if (md_neg) md_prod = -md_prod;
    case (md_op)
      3'b000:  md_result = md_prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  md_result = md_prod[2*XLEN-1:XLEN];
      3'b100:  md_result = md_div0 ? '1 : (md_neg ? -md_lo : md_lo);
      3'b101:  md_result = md_lo;
      3'b110:  md_result = md_negr ? -md_hi : md_hi;
      default: md_result = md_hi;
    endcase
  end
`else
  assign stall_out = 1'b0;
  assign md_result = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush_in || stall_out) begin
      ALUResult    <= '0;
      WriteData    <= '0;
      BranchTarget <= '0;
      BranchTaken  <= 1'b0;
      rd           <= '0;
      MemRead      <= 1'b0;
      MemtoReg     <= 1'b0;
      MemWrite     <= 1'b0;
      RegWrite     <= 1'b0;
    end else begin
      ALUResult    <= MulDiv_in ? md_result : alu_res;
      WriteData    <= fwd_b;
      BranchTarget <= PC_in + immData_in;
      BranchTaken  <= Branch_in & br_cond;
      rd           <= rd_in;
      MemRead      <= MemRead_in;
      MemtoReg     <= MemtoReg_in;
      MemWrite     <= MemWrite_in;
      RegWrite     <= RegWrite_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors, spec-level model checked every cycle, literal expectations.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_in, data1_in, data2_in, immData_in, fwd_mem_data, fwd_wb_data;
  logic [4:0]  rd_in;
  logic [3:0]  Funct_in;
  logic [1:0]  ALUOp_in, ForwardA, ForwardB;
  logic        Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in;
  logic        MulDiv_in, flush_in;
  logic        stall_out, BranchTaken, MemRead, MemtoReg, MemWrite, RegWrite;
  logic [31:0] ALUResult, WriteData, BranchTarget;
  logic [4:0]  rd;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  ex_stage dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .data1_in(data1_in), .data2_in(data2_in),
    .immData_in(immData_in), .rd_in(rd_in), .Funct_in(Funct_in), .ALUOp_in(ALUOp_in),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .RegWrite_in(RegWrite_in),
    .MulDiv_in(MulDiv_in), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .flush_in(flush_in),
    .stall_out(stall_out), .ALUResult(ALUResult), .WriteData(WriteData),
    .BranchTarget(BranchTarget), .BranchTaken(BranchTaken), .rd(rd), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sel_fwd(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
    if (s == 2'b10) return m;
    if (s == 2'b01) return w;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [3:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [3:0] f;
    f = fn;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11 && fn[2:0] != 3'b101) f[3] = 1'b0;
    case (f)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    case (fn)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  logic [31:0] m_a, m_b, m_opb;
  always_comb begin
    m_a   = sel_fwd(ForwardA, data1_in, fwd_mem_data, fwd_wb_data);
    m_b   = sel_fwd(ForwardB, data2_in, fwd_mem_data, fwd_wb_data);
    m_opb = ALUSrc_in ? immData_in : m_b;
  end

  logic [31:0] e_alu, e_wd, e_bt, md_res, md_val;
  logic [4:0]  e_rd;
  logic        e_tk, e_mr, e_m2r, e_mw, e_rw, bub;
  int          md_edges;
  localparam int MD_STALL = 33;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {e_alu, e_wd, e_bt, e_rd, e_tk, e_mr, e_m2r, e_mw, e_rw} = '0;
      md_edges = 0;
    end else begin
      md_val = 32'd0;
      bub    = flush_in;
`ifdef EX_MULDIV_EN
      if (flush_in) md_edges = 0;
      else if (MulDiv_in && md_edges < MD_STALL) begin
        if (md_edges == 0) md_res = ref_md(Funct_in[2:0], m_a, m_b);
        md_edges++;
        bub = 1'b1;
      end else begin
        md_val   = md_res;
        md_edges = 0;
      end
`endif
      if (bub) {e_alu, e_wd, e_bt, e_rd, e_tk, e_mr, e_m2r, e_mw, e_rw} = '0;
      else begin
        e_alu = MulDiv_in ? md_val : ref_alu(ALUOp_in, Funct_in, m_a, m_opb);
        e_wd  = m_b;
        e_bt  = PC_in + immData_in;
        e_tk  = Branch_in & ref_taken(Funct_in[2:0], m_a, m_opb);
        e_rd  = rd_in;
        e_mr  = MemRead_in; e_m2r = MemtoReg_in; e_mw = MemWrite_in; e_rw = RegWrite_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
`ifdef EX_MULDIV_EN
      chk("stall_out", {31'd0, stall_out}, {31'd0, reset & MulDiv_in & ~flush_in & (md_edges < MD_STALL)});
`else
      chk("stall_out", {31'd0, stall_out}, 32'd0);
`endif
      chk("ALUResult", ALUResult, e_alu);
      chk("WriteData", WriteData, e_wd);
      chk("BranchTarget", BranchTarget, e_bt);
      chk("BranchTaken", {31'd0, BranchTaken}, {31'd0, e_tk});
      chk("rd", {27'd0, rd}, {27'd0, e_rd});
      chk("ctrl", {28'd0, MemRead, MemtoReg, MemWrite, RegWrite}, {28'd0, e_mr, e_m2r, e_mw, e_rw});
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear();
    {PC_in, data1_in, data2_in, immData_in, fwd_mem_data, fwd_wb_data} = '0;
    rd_in = '0; Funct_in = '0; ALUOp_in = '0; ForwardA = '0; ForwardB = '0;
    {Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in} = '0;
    MulDiv_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [1:0] op; logic [3:0] fn; logic [31:0] a; logic [31:0] b; logic [31:0] r; } vec_t;
  vec_t vt[11];

`ifdef EX_MULDIV_EN
  task automatic run_md(input string name, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r);
    int n;
    clear();
    MulDiv_in = 1'b1; ALUOp_in = 2'b10; Funct_in = {1'b0, fn};
    data1_in = a; data2_in = b; RegWrite_in = 1'b1; rd_in = 5'd5;
    #1;
    n = 0;
    while (stall_out === 1'b1 && n < 40) begin
      n++;
      step();
      if (n == 1) begin data1_in = 32'h1234; data2_in = 32'h5678; end
    end
    chk({name, "_stalls"}, n, 33);
    step();
    chk(name, ALUResult, r);
    chk({name, "_rw"}, {31'd0, RegWrite}, 32'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{2'b10, 4'b1000, 32'd5,          32'd7,          32'hFFFFFFFE};
    vt[1]  = '{2'b10, 4'b0001, 32'd1,          32'd33,         32'd2};
    vt[2]  = '{2'b10, 4'b0010, 32'hFFFFFFFF,   32'd1,          32'd1};
    vt[3]  = '{2'b10, 4'b0011, 32'hFFFFFFFF,   32'd1,          32'd0};
    vt[4]  = '{2'b10, 4'b0100, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0};
    vt[5]  = '{2'b10, 4'b0101, 32'h80000000,   32'd4,          32'h08000000};
    vt[6]  = '{2'b10, 4'b0110, 32'hF0,         32'h0F,         32'hFF};
    vt[7]  = '{2'b10, 4'b0111, 32'hF0,         32'h3C,         32'h30};
    vt[8]  = '{2'b11, 4'b1000, 32'd5,          32'd7,          32'd12};
    vt[9]  = '{2'b11, 4'b0101, 32'h80000000,   32'd4,          32'h08000000};
    vt[10] = '{2'b00, 4'b0000, 32'hFFFFFFFF,   32'd1,          32'd0};

    reset = 1'b0;
    clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alu", ALUResult, 32'd0);
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    chk("reset_rw", {31'd0, RegWrite}, 32'd0);
    reset = 1'b1;
    chk_on = 1'b1;

    // add
    data1_in = 32'd5; data2_in = 32'd7; ALUOp_in = 2'b10; RegWrite_in = 1'b1; rd_in = 5'd3;
    step();
    chk("add", ALUResult, 32'd12);
    chk("add_rd", {27'd0, rd}, 32'd3);
    chk("add_rw", {31'd0, RegWrite}, 32'd1);

    // forwarded rs1 plus immediate, then srai
    clear();
    ForwardA = 2'b10; fwd_mem_data = 32'h100; data1_in = 32'd1; ALUSrc_in = 1'b1; immData_in = 32'd4;
    step();
    chk("fwd_mem_addi", ALUResult, 32'h104);
    clear();
    data1_in = 32'h80000000; Funct_in = 4'b1101; immData_in = 32'd4; ALUOp_in = 2'b11; ALUSrc_in = 1'b1;
    step();
    chk("srai", ALUResult, 32'hF8000000);

    // writeback forwarding on rs2 also feeds store data
    clear();
    ForwardB = 2'b01; fwd_wb_data = 32'd10; data1_in = 32'd3; data2_in = 32'd99; ALUOp_in = 2'b10;
    MemWrite_in = 1'b1;
    step();
    chk("fwd_wb_add", ALUResult, 32'd13);
    chk("fwd_wb_wd", WriteData, 32'd10);

    for (int i = 0; i < 11; i++) begin
      clear();
      ALUOp_in = vt[i].op; Funct_in = vt[i].fn; data1_in = vt[i].a; data2_in = vt[i].b;
      step();
      chk($sformatf("vec%0d", i), ALUResult, vt[i].r);
    end

    // branches
    clear();
    PC_in = 32'h40; immData_in = 32'h10; data1_in = 32'd9; data2_in = 32'd9;
    Branch_in = 1'b1; ALUOp_in = 2'b01; Funct_in = 4'b0000;
    step();
    chk("beq_taken", {31'd0, BranchTaken}, 32'd1);
    chk("beq_target", BranchTarget, 32'h50);
    Funct_in = 4'b0001;
    step();
    chk("bne_not", {31'd0, BranchTaken}, 32'd0);
    data1_in = 32'hFFFFFFFF; data2_in = 32'd1; Funct_in = 4'b0100;
    step();
    chk("blt_taken", {31'd0, BranchTaken}, 32'd1);
    Funct_in = 4'b0110;
    step();
    chk("bltu_not", {31'd0, BranchTaken}, 32'd0);

    // flush squashes the instruction
    clear();
    data1_in = 32'd5; data2_in = 32'd7; ALUOp_in = 2'b10; RegWrite_in = 1'b1; rd_in = 5'd7;
    flush_in = 1'b1;
    step();
    chk("flush_alu", ALUResult, 32'd0);
    chk("flush_rw", {31'd0, RegWrite}, 32'd0);

    // reset asserted mid-cycle clears immediately
    clear();
    data1_in = 32'd20; data2_in = 32'd22; ALUOp_in = 2'b10; RegWrite_in = 1'b1; rd_in = 5'd9;
    step();
    chk("pre_reset", ALUResult, 32'd42);
    reset = 1'b0;
    #1;
    chk("midreset_alu", ALUResult, 32'd0);
    chk("midreset_rd", {27'd0, rd}, 32'd0);
    chk("midreset_stall", {31'd0, stall_out}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset", ALUResult, 32'd42);
    chk("post_reset_rd", {27'd0, rd}, 32'd9);

`ifdef EX_MULDIV_EN
    run_md("mul", 3'b000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
    run_md("mulh", 3'b001, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF);
    run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    run_md("mulhu", 3'b011, 32'hFFFFFFFF, 32'd3, 32'd2);
    run_md("div0", 3'b100, 32'd7, 32'd0, 32'hFFFFFFFF);
    run_md("rem0", 3'b110, 32'd7, 32'd0, 32'd7);
    run_md("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_md("divneg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_md("remneg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_md("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_md("remu", 3'b111, 32'd100, 32'd7, 32'd2);

    // flush mid-operation, then the same op completes from scratch
    clear();
    MulDiv_in = 1'b1; ALUOp_in = 2'b10; data1_in = 32'd6; data2_in = 32'd7; RegWrite_in = 1'b1;
    repeat (11) step();
    flush_in = 1'b1;
    #1;
    chk("flush_busy_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("flush_busy_alu", ALUResult, 32'd0);
    chk("flush_busy_rw", {31'd0, RegWrite}, 32'd0);
    run_md("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42);
`else
    clear();
    MulDiv_in = 1'b1; ALUOp_in = 2'b10; data1_in = 32'd5; data2_in = 32'd7; RegWrite_in = 1'b1; rd_in = 5'd4;
    #1;
    chk("md_off_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("md_off_alu", ALUResult, 32'd0);
    chk("md_off_rw", {31'd0, RegWrite}, 32'd1);
    chk("md_off_rd", {27'd0, rd}, 32'd4);
`endif

    clear();
    step();
    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
